// File: rtl/cross_overlay.sv
// cross_overlay: two-tone crosshair overlay for the VGA pixel path.
// Blue outer cross with a black inner core, drawn around a runtime-movable
// centre that only changes at frame boundaries. One cycle of pixel latency.
// Optional blinking is enabled by defining the macro CROSS_BLINK_EN.
module cross_overlay #(
  parameter int          H_RES        = 640,
  parameter int          V_RES        = 480,
  parameter int          CX_INIT      = 320,
  parameter int          CY_INIT      = 215,
  parameter int          ARM_LEN      = 10,
  parameter int          OUTER_HW     = 2,
  parameter int          INNER_HW     = 0,
  parameter logic [9:0]  NULL_VALUE   = 10'h400,
  parameter int          BLINK_FRAMES = 30
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] px,
  input  logic [9:0] py,
  input  logic       pix_valid,
  input  logic       frame_start,
  input  logic       move_valid,
  output logic       move_ready,
  input  logic [5:0] move_dx,
  input  logic [5:0] move_dy,
  output logic [9:0] center_x,
  output logic [9:0] center_y,
  output logic [9:0] r,
  output logic [9:0] g,
  output logic [9:0] b,
  output logic       is_printed
);

  // Clamp limits keep the whole crosshair on screen.
  localparam logic signed [11:0] X_LO = 12'(ARM_LEN);
  localparam logic signed [11:0] X_HI = 12'(H_RES - 1 - ARM_LEN);
  localparam logic signed [11:0] Y_LO = 12'(ARM_LEN);
  localparam logic signed [11:0] Y_HI = 12'(V_RES - 1 - ARM_LEN);

  localparam logic [10:0] ARM_U   = 11'(ARM_LEN);
  localparam logic [10:0] OUTER_U = 11'(OUTER_HW);
  localparam logic [10:0] INNER_U = 11'(INNER_HW);

  function automatic logic [9:0] clamp(input logic signed [11:0] v,
                                       input logic signed [11:0] lo,
                                       input logic signed [11:0] hi);
    logic [9:0] res;
    if (v < lo)      res = lo[9:0];
    else if (v > hi) res = hi[9:0];
    else             res = v[9:0];
    return res;
  endfunction

  logic [9:0] tgt_x, tgt_y;
  logic [9:0] cx, cy;
  logic       pending;
  logic       accept;
  logic signed [11:0] sum_x, sum_y;
  logic [9:0] new_x, new_y;

  assign move_ready = !pending;
  assign accept     = move_valid && !pending;
  assign center_x   = cx;
  assign center_y   = cy;

  // New target: 12-bit signed sum of target and sign-extended delta, clamped.
  always_comb begin
    sum_x = $signed({2'b00, tgt_x}) + $signed({{6{move_dx[5]}}, move_dx});
    sum_y = $signed({2'b00, tgt_y}) + $signed({{6{move_dy[5]}}, move_dy});
    new_x = clamp(sum_x, X_LO, X_HI);
    new_y = clamp(sum_y, Y_LO, Y_HI);
  end

  // Target/active centre and the pending flag; active only changes at frame_start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tgt_x   <= 10'(CX_INIT);
      tgt_y   <= 10'(CY_INIT);
      cx      <= 10'(CX_INIT);
      cy      <= 10'(CY_INIT);
      pending <= 1'b0;
    end else begin
      if (accept) begin
        tgt_x <= new_x;
        tgt_y <= new_y;
      end
      if (frame_start) begin
        // A move accepted on the frame boundary goes straight to active.
        cx      <= accept ? new_x : tgt_x;
        cy      <= accept ? new_y : tgt_y;
        pending <= 1'b0;
      end else if (accept) begin
        pending <= 1'b1;
      end
    end
  end

  logic visible;

`ifdef CROSS_BLINK_EN
  localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  logic [BW-1:0] blink_cnt;

  // Frame counter toggles visibility every BLINK_FRAMES frames.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt <= '0;
      visible   <= 1'b1;
    end else if (frame_start) begin
      if (blink_cnt == BW'(BLINK_FRAMES - 1)) begin
        blink_cnt <= '0;
        visible   <= ~visible;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end
    end
  end
`else
  assign visible = 1'b1;
`endif

  logic signed [10:0] dx, dy;
  logic [10:0] adx, ady;
  logic inner, outer;

  // Classify the current pixel against the active centre.
  always_comb begin
    dx    = $signed({1'b0, px}) - $signed({1'b0, cx});
    dy    = $signed({1'b0, py}) - $signed({1'b0, cy});
    adx   = dx[10] ? 11'(-dx) : 11'(dx);
    ady   = dy[10] ? 11'(-dy) : 11'(dy);
    outer = ((adx <= ARM_U) && (ady <= OUTER_U)) || ((adx <= OUTER_U) && (ady <= ARM_U));
    inner = ((adx <= ARM_U) && (ady <= INNER_U)) || ((adx <= INNER_U) && (ady <= ARM_U));
  end

  // Registered pixel-mux outputs: black core, blue outer, else NULL.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r          <= NULL_VALUE;
      g          <= NULL_VALUE;
      b          <= NULL_VALUE;
      is_printed <= 1'b0;
    end else if (pix_valid && visible && inner) begin
      r          <= 10'h000;
      g          <= 10'h000;
      b          <= 10'h000;
      is_printed <= 1'b1;
    end else if (pix_valid && visible && outer) begin
      r          <= 10'h000;
      g          <= 10'h000;
      b          <= 10'h3FF;
      is_printed <= 1'b1;
    end else begin
      r          <= NULL_VALUE;
      g          <= NULL_VALUE;
      b          <= NULL_VALUE;
      is_printed <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cross_overlay.sv
// Testbench for cross_overlay: behavioural model plus directed literal checks.
module tb_cross_overlay;

  localparam int TB_BF = 2;
  localparam logic [9:0] NV = 10'h400;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [9:0] px = '0, py = '0;
  logic pix_valid = 1'b0, frame_start = 1'b0, move_valid = 1'b0;
  logic [5:0] move_dx = '0, move_dy = '0;
  logic move_ready;
  logic [9:0] center_x, center_y, r, g, b;
  logic is_printed;

  int checks = 0;
  int failures = 0;
  logic chk_en = 1'b0;

  cross_overlay #(.BLINK_FRAMES(TB_BF)) dut (
    .clk(clk), .rst_n(rst_n), .px(px), .py(py), .pix_valid(pix_valid),
    .frame_start(frame_start), .move_valid(move_valid), .move_ready(move_ready),
    .move_dx(move_dx), .move_dy(move_dy), .center_x(center_x), .center_y(center_y),
    .r(r), .g(g), .b(b), .is_printed(is_printed)
  );

  always #5 clk = ~clk;

  task automatic cmp(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int m_tx, m_ty, m_cx, m_cy, m_cnt;
  bit m_pend, m_vis;
  int e_r, e_g, e_b, e_p;

  function automatic int clampi(input int v, input int lo, input int hi);
    return (v < lo) ? lo : ((v > hi) ? hi : v);
  endfunction

  // 0 = not drawn, 1 = blue, 2 = black
  function automatic int pix_class(input int x, input int y, input int cx, input int cy);
    int ax, ay;
    ax = (x > cx) ? x - cx : cx - x;
    ay = (y > cy) ? y - cy : cy - y;
    if ((ax <= 10 && ay == 0) || (ax == 0 && ay <= 10)) return 2;
    if ((ax <= 10 && ay <= 2) || (ax <= 2 && ay <= 10)) return 1;
    return 0;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_tx <= 320; m_ty <= 215; m_cx <= 320; m_cy <= 215;
      m_pend <= 1'b0; m_vis <= 1'b1; m_cnt <= 0;
      e_r <= NV; e_g <= NV; e_b <= NV; e_p <= 0;
    end else begin
      if (move_valid && !m_pend) begin
        m_tx <= clampi(m_tx + int'($signed(move_dx)), 10, 629);
        m_ty <= clampi(m_ty + int'($signed(move_dy)), 10, 469);
      end
      if (frame_start) begin
        m_cx <= (move_valid && !m_pend) ? clampi(m_tx + int'($signed(move_dx)), 10, 629) : m_tx;
        m_cy <= (move_valid && !m_pend) ? clampi(m_ty + int'($signed(move_dy)), 10, 469) : m_ty;
        m_pend <= 1'b0;
      end else if (move_valid) begin
        m_pend <= 1'b1;
      end
`ifdef CROSS_BLINK_EN
      if (frame_start) begin
        if (m_cnt == TB_BF - 1) begin m_cnt <= 0; m_vis <= !m_vis; end
        else m_cnt <= m_cnt + 1;
      end
`endif
      case ((pix_valid && m_vis) ? pix_class(int'(px), int'(py), m_cx, m_cy) : 0)
        2:       begin e_r <= 0; e_g <= 0; e_b <= 0;     e_p <= 1; end
        1:       begin e_r <= 0; e_g <= 0; e_b <= 'h3FF; e_p <= 1; end
        default: begin e_r <= NV; e_g <= NV; e_b <= NV; e_p <= 0; end
      endcase
    end
  end

  // Compare process: every cycle on the falling edge.
  always @(negedge clk) begin
    if (chk_en) begin
      cmp("model_r", int'(r), e_r);
      cmp("model_g", int'(g), e_g);
      cmp("model_b", int'(b), e_b);
      cmp("model_printed", int'(is_printed), e_p);
      cmp("model_cx", int'(center_x), m_cx);
      cmp("model_cy", int'(center_y), m_cy);
      cmp("model_ready", int'(move_ready), int'(!m_pend));
    end
  end

  // ---------------- stimulus ----------------
  // Apply inputs at a falling edge, return at the next falling edge.
  task automatic drive(input int x, input int y, input bit pv, input bit fs,
                       input bit mv, input int dx, input int dy);
    px = 10'(x); py = 10'(y); pix_valid = pv; frame_start = fs;
    move_valid = mv; move_dx = 6'(dx); move_dy = 6'(dy);
    @(negedge clk);
  endtask

  task automatic pix(input string name, input int x, input int y, input int kind);
    drive(x, y, 1'b1, 1'b0, 1'b0, 0, 0);
    cmp({name, "_r"}, int'(r), (kind == 0) ? int'(NV) : 0);
    cmp({name, "_g"}, int'(g), (kind == 0) ? int'(NV) : 0);
    cmp({name, "_b"}, int'(b), (kind == 0) ? int'(NV) : ((kind == 1) ? 'h3FF : 0));
    cmp({name, "_p"}, int'(is_printed), (kind == 0) ? 0 : 1);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    chk_en = 1'b1;
    cmp("rst_b", int'(b), int'(NV));
    cmp("rst_ready", int'(move_ready), 1);
    cmp("rst_cx", int'(center_x), 320);

    // 1: classification around the reset centre
    pix("centre", 320, 215, 2);
    pix("arm_mid", 330, 216, 1);
    pix("arm_end", 331, 215, 0);
    pix("corner", 322, 217, 1);
    pix("off_diag", 323, 218, 0);
    drive(330, 215, 1'b0, 1'b0, 1'b0, 0, 0);
    cmp("pv0_p", int'(is_printed), 0);

    // 2: move stalls until frame_start
    drive(0, 0, 1'b0, 1'b0, 1'b1, 5, 0);
    cmp("pend_ready", int'(move_ready), 0);
    pix("old_centre", 320, 215, 2);
    cmp("pend_cx", int'(center_x), 320);
    drive(0, 0, 1'b0, 1'b1, 1'b0, 0, 0);
    cmp("fs_cx", int'(center_x), 325);
    cmp("fs_ready", int'(move_ready), 1);
    pix("new_centre", 325, 215, 2);

    // 3: move in the frame_start cycle goes straight to active
    drive(0, 0, 1'b0, 1'b1, 1'b1, 0, -3);
    cmp("same_cy", int'(center_y), 212);
    cmp("same_ready", int'(move_ready), 1);

    // 4: saturation at both x limits
    for (int i = 0; i < 12; i++) drive(0, 0, 1'b0, 1'b1, 1'b1, -31, 0);
    cmp("sat_lo_cx", int'(center_x), 10);
    pix("left_edge", 0, 213, 1);
    pix("left_wrap", 639, 212, 0);
    for (int i = 0; i < 21; i++) drive(0, 0, 1'b0, 1'b1, 1'b1, 31, 0);
    cmp("sat_hi_cx", int'(center_x), 629);
    pix("right_edge", 639, 213, 1);

    // 6: async reset while a move is pending
    drive(0, 0, 1'b0, 1'b0, 1'b1, 1, 1);
    cmp("pre_rst_ready", int'(move_ready), 0);
    pix("pre_rst", 629, 212, 2);
    move_valid = 1'b0; pix_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    cmp("arst_cx", int'(center_x), 320);
    cmp("arst_cy", int'(center_y), 215);
    cmp("arst_ready", int'(move_ready), 1);
    cmp("arst_b", int'(b), int'(NV));
    cmp("arst_p", int'(is_printed), 0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(0, 0, 1'b0, 1'b1, 1'b0, 0, 0);
    cmp("post_rst_cx", int'(center_x), 320);

`ifdef CROSS_BLINK_EN
    // 5: blink after two frame_starts (one already issued above)
    drive(0, 0, 1'b0, 1'b1, 1'b0, 0, 0);
    pix("blink_off", 320, 215, 0);
    drive(0, 0, 1'b0, 1'b1, 1'b0, 0, 0);
    drive(0, 0, 1'b0, 1'b1, 1'b0, 0, 0);
    pix("blink_on", 320, 215, 2);
`else
    pix("no_blink", 320, 215, 2);
`endif

    drive(0, 0, 1'b0, 1'b0, 1'b0, 0, 0);
    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
